mmc5_snd_multi: RTL and testbench

- Parametrised successor to the cartridge expansion-sound unit: CHANNELS pulse voices, an 8-bit PCM register, and an internal frame sequencer, all on one clock.
- Adds an optional sweep unit, a status read-back, a registered linear mix, and an on-chip first-order delta-sigma 1-bit output. No separate PWM clock.
- Sits on the CPU bus beside the mapper's PRG/CHR logic; its outputs feed the cartridge audio pin.

---
 rtl/mmc5_snd_multi.sv | 183 ++++++++++++++++++
 tb/tb_mmc5_snd_multi.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc5_snd_multi.sv
// Multi-voice cartridge expansion sound: pulse voices with envelope, length
// and optional sweep, an 8-bit PCM register, registered mix and 1-bit delta-sigma output.
module mmc5_snd_multi #(
   parameter int          CHANNELS  = 2,
   parameter logic [14:0] BASE      = 15'h5000,
   parameter logic [14:0] PCM_ADDR  = 15'h5011,
   parameter logic [14:0] CTRL_ADDR = 15'h5015,
   parameter int          FRAME_DIV = 7457,
   parameter bit          SWEEP_EN  = 1'b0
) (
   input  logic        m2,
   input  logic        rst,
   input  logic [14:0] cpu_addr,
   input  logic [7:0]  cpu_dat,
   input  logic        cpu_rw,
   input  logic        cpu_ce,
   output logic [7:0]  cpu_dout,
   output logic        cpu_oe,
   output logic [10:0] mix,
   output logic        pwm
);

   localparam int FCW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [FCW-1:0] FC_LAST = FCW'(FRAME_DIV - 1);
   localparam logic [7:0] DUTY_TAB [4] = '{8'h40, 8'h60, 8'h78, 8'h9F};
   localparam logic [7:0] LEN_TAB [32] = '{
      8'd10, 8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
      8'd160, 8'd8,  8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
      8'd12, 8'd16,  8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
      8'd192, 8'd24, 8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30};

   logic [FCW-1:0] fc_q;
   logic           half_ph_q;
   logic [7:0]     pcm_q;
   logic [10:0]    mix_q, acc_q;
   logic           pwm_q;
   logic [7:0]     r0_q      [CHANNELS];
   logic [7:0]     r1_q      [CHANNELS];
   logic [10:0]    t_q       [CHANNELS];
   logic [10:0]    tcnt_q    [CHANNELS];
   logic           tog_q     [CHANNELS];
   logic [2:0]     step_q    [CHANNELS];
   logic [7:0]     len_q     [CHANNELS];
   logic           en_q      [CHANNELS];
   logic           env_st_q  [CHANNELS];
   logic [3:0]     env_q     [CHANNELS];
   logic [3:0]     env_div_q [CHANNELS];
   logic [2:0]     sw_div_q  [CHANNELS];
   logic           sw_rld_q  [CHANNELS];

   logic           we, wr_pcm, wr_ctrl, qtick, htick;
   logic [10:0]    mix_d;
   logic [11:0]    ds_d;
   logic [7:0]     status;
   logic [3:0]     wr_ch  [CHANNELS];
   logic [11:0]    delta  [CHANNELS];
   logic [11:0]    target [CHANNELS];
   logic           mute   [CHANNELS];
   logic [3:0]     ch_out [CHANNELS];

   // Bus: a write is any cpu_ce cycle with cpu_rw low on a mapped address, taken
   // at the sampling edge; reads are combinational and only the CTRL address drives.
   assign we      = cpu_ce & ~cpu_rw;
   assign wr_pcm  = we & (cpu_addr == PCM_ADDR);
   assign wr_ctrl = we & (cpu_addr == CTRL_ADDR);
   assign qtick   = (fc_q == FC_LAST);
   assign htick   = qtick & half_ph_q;
   assign cpu_oe  = cpu_ce & cpu_rw & (cpu_addr == CTRL_ADDR);
   assign cpu_dout = cpu_oe ? status : 8'h00;
   assign mix     = mix_q;
   assign pwm     = pwm_q;
   assign ds_d    = {1'b0, acc_q} + {1'b0, mix_q};

   always_comb begin
      mix_d  = {3'b000, pcm_q};
      status = 8'h00;
      for (int n = 0; n < CHANNELS; n++) begin
         wr_ch[n] = 4'b0000;
         for (int r = 0; r < 4; r++)
            wr_ch[n][r] = we & (cpu_addr == 15'(int'(BASE) + 4*n + r));
         delta[n]  = {1'b0, t_q[n]} >> r1_q[n][2:0];
         target[n] = r1_q[n][3] ? ({1'b0, t_q[n]} - delta[n] - 12'(n == 0))
                                : ({1'b0, t_q[n]} + delta[n]);
         mute[n]   = (SWEEP_EN != 1'b0) && ((t_q[n] < 11'd8) || (target[n] > 12'h7FF));
         ch_out[n] = 4'd0;
         if (en_q[n] && (len_q[n] != 8'd0) && !mute[n] && DUTY_TAB[r0_q[n][7:6]][step_q[n]])
            ch_out[n] = r0_q[n][4] ? r0_q[n][3:0] : env_q[n];
         mix_d     = mix_d + {3'b000, ch_out[n], 4'b0000};
         status[n] = (len_q[n] != 8'd0);
      end
   end

   always_ff @(posedge m2) begin
      if (rst) begin
         fc_q      <= '0;
         half_ph_q <= 1'b0;
         pcm_q     <= '0;
         mix_q     <= '0;
         acc_q     <= '0;
         pwm_q     <= 1'b0;
         for (int n = 0; n < CHANNELS; n++) begin
            r0_q[n]      <= '0;
            r1_q[n]      <= '0;
            t_q[n]       <= '0;
            tcnt_q[n]    <= '0;
            tog_q[n]     <= 1'b0;
            step_q[n]    <= '0;
            len_q[n]     <= '0;
            en_q[n]      <= 1'b0;
            env_st_q[n]  <= 1'b0;
            env_q[n]     <= '0;
            env_div_q[n] <= '0;
            sw_div_q[n]  <= '0;
            sw_rld_q[n]  <= 1'b0;
         end
      end else begin
         fc_q <= qtick ? '0 : fc_q + FCW'(1);
         if (qtick) half_ph_q <= ~half_ph_q;
         if (wr_pcm) pcm_q <= cpu_dat;
         mix_q <= mix_d;
         {pwm_q, acc_q} <= ds_d;
         for (int n = 0; n < CHANNELS; n++) begin
            if (wr_ctrl)     en_q[n] <= cpu_dat[n];
            if (wr_ch[n][0]) r0_q[n] <= cpu_dat;
            if (wr_ch[n][1]) r1_q[n] <= cpu_dat;

            if (tcnt_q[n] == 11'd0) begin
               tcnt_q[n] <= t_q[n];
               tog_q[n]  <= ~tog_q[n];
            end else begin
               tcnt_q[n] <= tcnt_q[n] - 11'd1;
            end
            if (wr_ch[n][3])
               step_q[n] <= 3'd0;
            else if ((tcnt_q[n] == 11'd0) && tog_q[n])
               step_q[n] <= step_q[n] + 3'd1;

            // CPU period writes win over a coincident sweep update
            if (wr_ch[n][2])
               t_q[n][7:0] <= cpu_dat;
            else if (wr_ch[n][3])
               t_q[n][10:8] <= cpu_dat[2:0];
            else if ((SWEEP_EN != 1'b0) && htick && (sw_div_q[n] == 3'd0) && r1_q[n][7] &&
                     (r1_q[n][2:0] != 3'd0) && !mute[n])
               t_q[n] <= target[n][10:0];

            if (!en_q[n])
               len_q[n] <= 8'd0;
            else if (wr_ch[n][3])
               len_q[n] <= LEN_TAB[cpu_dat[7:3]];
            else if (htick && (len_q[n] != 8'd0) && !r0_q[n][5])
               len_q[n] <= len_q[n] - 8'd1;

            if (wr_ch[n][3]) begin
               env_st_q[n] <= 1'b1;
            end else if (qtick) begin
               if (env_st_q[n]) begin
                  env_st_q[n]  <= 1'b0;
                  env_q[n]     <= 4'd15;
                  env_div_q[n] <= r0_q[n][3:0];
               end else if (env_div_q[n] != 4'd0) begin
                  env_div_q[n] <= env_div_q[n] - 4'd1;
               end else begin
                  env_div_q[n] <= r0_q[n][3:0];
                  if (env_q[n] != 4'd0)  env_q[n] <= env_q[n] - 4'd1;
                  else if (r0_q[n][5])   env_q[n] <= 4'd15;
               end
            end

            if (wr_ch[n][3])
               sw_div_q[n] <= r1_q[n][6:4];
            else if (htick)
               sw_div_q[n] <= ((sw_div_q[n] == 3'd0) || sw_rld_q[n]) ? r1_q[n][6:4]
                                                                     : sw_div_q[n] - 3'd1;
            if (wr_ch[n][1])
               sw_rld_q[n] <= 1'b1;
            else if (htick && ((sw_div_q[n] == 3'd0) || sw_rld_q[n]))
               sw_rld_q[n] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mmc5_snd_multi.sv
// Bench for mmc5_snd_multi: directed steps plus random bus traffic, each cycle
// checked against a behavioural model of the sound unit.
module tb_mmc5_snd_multi;

   localparam int NCH = 2;
   localparam int FD  = 40;
   localparam logic [14:0] BASE   = 15'h5000;
   localparam logic [14:0] PCM_A  = 15'h5011;
   localparam logic [14:0] CTRL_A = 15'h5015;

   logic        m2 = 1'b0;
   logic        rst = 1'b0;
   logic [14:0] cpu_addr = '0;
   logic [7:0]  cpu_dat = '0;
   logic        cpu_rw = 1'b1;
   logic        cpu_ce = 1'b0;
   logic [7:0]  cpu_dout;
   logic        cpu_oe;
   logic [10:0] mix;
   logic        pwm;

   int vecs = 0;
   int errs = 0;

   always #5 m2 = ~m2;

   mmc5_snd_multi #(
      .CHANNELS(NCH), .BASE(BASE), .PCM_ADDR(PCM_A), .CTRL_ADDR(CTRL_A),
      .FRAME_DIV(FD), .SWEEP_EN(1'b1)
   ) dut (
      .m2(m2), .rst(rst), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat), .cpu_rw(cpu_rw),
      .cpu_ce(cpu_ce), .cpu_dout(cpu_dout), .cpu_oe(cpu_oe), .mix(mix), .pwm(pwm)
   );

   // ---------------- behavioural model ----------------
   int len_tab [32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                        12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};
   int duty_tab [4] = '{'h40, 'h60, 'h78, 'h9F};
   int m_fc, m_pcm, m_mix, m_acc;
   bit m_hph, m_pwm;
   int m_r0 [NCH], m_r1 [NCH], m_t [NCH], m_tc [NCH], m_step [NCH];
   int m_len [NCH], m_env [NCH], m_ed [NCH], m_sd [NCH];
   bit m_tog [NCH], m_en [NCH], m_st [NCH], m_rl [NCH];

   task automatic model_reset();
      m_fc = 0; m_hph = 0; m_pcm = 0; m_mix = 0; m_acc = 0; m_pwm = 0;
      for (int n = 0; n < NCH; n++) begin
         m_r0[n] = 0; m_r1[n] = 0; m_t[n] = 0; m_tc[n] = 0; m_step[n] = 0;
         m_len[n] = 0; m_env[n] = 0; m_ed[n] = 0; m_sd[n] = 0;
         m_tog[n] = 0; m_en[n] = 0; m_st[n] = 0; m_rl[n] = 0;
      end
   endtask

   function automatic int m_target(input int n);
      int dl;
      dl = m_t[n] >> (m_r1[n] & 7);
      if ((m_r1[n] & 8) != 0) return m_t[n] - dl - ((n == 0) ? 1 : 0);
      return m_t[n] + dl;
   endfunction

   function automatic bit m_mute(input int n);
      return (m_t[n] < 8) || (m_target(n) > 'h7FF);
   endfunction

   function automatic int m_out(input int n);
      bit on;
      on = m_en[n] && (m_len[n] != 0) && !m_mute(n) &&
           (((duty_tab[(m_r0[n] >> 6) & 3] >> m_step[n]) & 1) != 0);
      if (!on) return 0;
      return ((m_r0[n] & 16) != 0) ? (m_r0[n] & 15) : m_env[n];
   endfunction

   function automatic int m_status();
      int s;
      s = 0;
      for (int n = 0; n < NCH; n++) if (m_len[n] != 0) s = s | (1 << n);
      return s;
   endfunction

   task automatic model_step(input logic [14:0] a, input logic [7:0] d, input logic rw,
                             input logic ce, input logic r);
      bit q, h, we;
      int mix_next;
      if (r) begin
         model_reset();
      end else begin
         q  = (m_fc == FD - 1);
         h  = q && m_hph;
         we = ce && !rw;
         mix_next = m_pcm;
         for (int n = 0; n < NCH; n++) mix_next += 16 * m_out(n);
         m_acc = m_acc + m_mix;
         m_pwm = (m_acc >= 2048);
         m_acc = m_acc % 2048;
         m_mix = mix_next;
         for (int n = 0; n < NCH; n++) begin
            int off, tg;
            bit w0, w1, w2, w3, fire, srl;
            off  = int'(a) - int'(BASE) - 4 * n;
            w0 = we && off == 0; w1 = we && off == 1; w2 = we && off == 2; w3 = we && off == 3;
            tg   = m_target(n);
            fire = h && m_sd[n] == 0 && (m_r1[n] & 'h80) != 0 && (m_r1[n] & 7) != 0 && !m_mute(n);
            srl  = h && (m_sd[n] == 0 || m_rl[n]);
            if (!m_en[n]) m_len[n] = 0;
            else if (w3) m_len[n] = len_tab[d >> 3];
            else if (h && m_len[n] != 0 && (m_r0[n] & 32) == 0) m_len[n]--;
            if (w3) m_st[n] = 1;
            else if (q) begin
               if (m_st[n]) begin m_st[n] = 0; m_env[n] = 15; m_ed[n] = m_r0[n] & 15; end
               else if (m_ed[n] != 0) m_ed[n]--;
               else begin
                  m_ed[n] = m_r0[n] & 15;
                  if (m_env[n] != 0) m_env[n]--;
                  else if ((m_r0[n] & 32) != 0) m_env[n] = 15;
               end
            end
            if (m_tc[n] == 0) begin
               if (m_tog[n]) m_step[n] = (m_step[n] + 1) % 8;
               m_tc[n] = m_t[n];
               m_tog[n] = !m_tog[n];
            end else m_tc[n]--;
            if (w3) m_step[n] = 0;
            if (w3) m_sd[n] = (m_r1[n] >> 4) & 7;
            else if (h) m_sd[n] = srl ? ((m_r1[n] >> 4) & 7) : m_sd[n] - 1;
            if (w1) m_rl[n] = 1;
            else if (srl) m_rl[n] = 0;
            if (w2) m_t[n] = (m_t[n] & 'h700) | int'(d);
            else if (w3) m_t[n] = (m_t[n] & 'hFF) | ((int'(d) & 7) << 8);
            else if (fire) m_t[n] = tg;
            if (w0) m_r0[n] = int'(d);
            if (w1) m_r1[n] = int'(d);
         end
         if (we && a == CTRL_A) for (int n = 0; n < NCH; n++) m_en[n] = d[n];
         if (we && a == PCM_A) m_pcm = int'(d);
         m_fc = q ? 0 : m_fc + 1;
         if (q) m_hph = !m_hph;
      end
   endtask

   // ---------------- driver and checks ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic [14:0] a, input logic [7:0] d, input logic rw, input logic ce);
      logic exp_oe;
      @(negedge m2);
      cpu_addr = a; cpu_dat = d; cpu_rw = rw; cpu_ce = ce;
      @(posedge m2);
      model_step(a, d, rw, ce, rst);
      #1;
      exp_oe = ce && rw && (a == CTRL_A);
      chk("mix", mix, m_mix);
      chk("pwm", pwm, m_pwm);
      chk("oe", cpu_oe, exp_oe);
      chk("dout", cpu_dout, exp_oe ? m_status() : 0);
   endtask

   task automatic rd();
      cyc(CTRL_A, 8'h00, 1'b1, 1'b1);
   endtask

   task automatic wr(input logic [14:0] a, input logic [7:0] d);
      cyc(a, d, 1'b0, 1'b1);
   endtask

   function automatic logic [14:0] chreg(input int ch, input int r);
      return BASE + 15'(4 * ch + r);
   endfunction

   initial begin
      int cnt;
      model_reset();
      // power-on reset
      rst = 1'b1; rd(); rd(); rst = 1'b0;
      chk("por_mix", mix, 0);
      chk("por_dout", cpu_dout, 0);

      // steady note on channel 0: duty 2 at T=8 gives 4 of 8 steps, 18 cycles each
      wr(CTRL_A, 8'h01);
      wr(chreg(0, 0), 8'hBF);
      wr(chreg(0, 2), 8'h08);
      wr(chreg(0, 3), 8'h08);
      repeat (40) rd();
      chk("status_ch0", cpu_dout, 8'h01);
      cnt = 0;
      for (int i = 0; i < 144; i++) begin rd(); if (mix == 11'd240) cnt++; end
      chk("duty_on_cycles", cnt, 72);

      // reset in the middle of the note
      rst = 1'b1; rd(); rd(); rst = 1'b0;
      chk("rst_mix", mix, 0);
      chk("rst_pwm", pwm, 0);
      chk("rst_dout", cpu_dout, 0);

      // envelope note with a two-half-tick length
      wr(CTRL_A, 8'h01);
      wr(chreg(0, 0), 8'h05);
      wr(chreg(0, 2), 8'($urandom_range(8, 30)));
      wr(chreg(0, 3), 8'h18);
      rd();
      chk("len2_status", cpu_dout, 8'h01);
      for (int i = 0; i < 6 * FD; i++) begin rd(); if (cpu_dout[0] == 1'b0) break; end
      chk("len_clear", cpu_dout[0], 0);
      repeat (4) rd();
      chk("out_after_len", mix, 0);

      // length load coinciding with a half tick while len = 5
      wr(chreg(0, 0), 8'h1F);
      wr(chreg(0, 3), 8'h38);
      for (int i = 0; i < 4 * FD && m_len[0] != 5; i++) rd();
      for (int i = 0; i < 4 * FD && !(m_fc == FD - 1 && m_hph); i++) rd();
      wr(chreg(0, 3), 8'h08);
      repeat (10 * FD) rd();
      chk("load_priority", cpu_dout[0], 1);
      wr(CTRL_A, 8'h00);
      rd();
      chk("ctrl_off", cpu_dout, 0);

      // negate sweep on both channels from T=0x100 down to the T<8 mute
      wr(PCM_A, 8'h00);
      wr(CTRL_A, 8'h03);
      for (int ch = 0; ch < NCH; ch++) begin
         wr(chreg(ch, 0), 8'hBF);
         wr(chreg(ch, 1), 8'h89);
         wr(chreg(ch, 2), 8'h00);
         wr(chreg(ch, 3), 8'h01);
      end
      rd();
      chk("sweep_status", cpu_dout, 8'h03);
      repeat (24 * FD) rd();
      chk("sweep_mute", mix, 0);

      // overflowing target mutes immediately (duty 3, step 0 would be high)
      wr(CTRL_A, 8'h01);
      wr(chreg(0, 0), 8'hFF);
      wr(chreg(0, 1), 8'h81);
      wr(chreg(0, 2), 8'hFF);
      wr(chreg(0, 3), 8'h07);
      repeat (3) rd();
      chk("ovf_mute", mix, 0);

      // PCM alone: mix 128, pwm density 128/2048
      wr(CTRL_A, 8'h00);
      wr(PCM_A, 8'h80);
      repeat (4) rd();
      chk("pcm_mix", mix, 128);
      cnt = 0;
      for (int i = 0; i < 2048; i++) begin rd(); if (pwm) cnt++; end
      chk("pwm_count", cnt, 128);

      // random bus traffic against the model
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            logic [14:0] a;
            int sel;
            sel = $urandom_range(0, 11);
            if (sel < 8)       a = BASE + 15'(sel);
            else if (sel == 8) a = PCM_A;
            else if (sel == 9) a = CTRL_A;
            else if (sel == 10) a = 15'h5010 + 15'($urandom_range(2, 4));
            else               a = 15'($urandom_range(0, 32767));
            cyc(a, 8'($urandom), 1'b0, 1'($urandom_range(0, 3) != 0));
         end else begin
            cyc(15'($urandom_range(32'h5000, 32'h5017)), 8'($urandom), 1'b1,
                1'($urandom_range(0, 1)));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
